// File: rtl/key_updown_counter.sv
// Debounced push-button up/down/clear counter; optional auto-repeat under KEY_AUTOREPEAT_EN.
// Latency: pulse HOLD_CYCLES+2 edges after first low sample, count one edge later.
// Backpressure: none; keys are free-running level inputs, every accepted event is applied.
module key_updown_counter #(
    parameter int WIDTH         = 4,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int SAT_MODE      = 0,
    parameter int STEP          = 1,
    parameter int REPEAT_CYCLES = 12500000
) (
    input  logic             FPGA_CLK,
    input  logic             RESET_BUT,
    input  logic             KEY_INC,
    input  logic             KEY_DEC,
    input  logic             KEY_CLR,
    output logic [WIDTH-1:0] count,
    output logic             inc_pulse,
    output logic             dec_pulse,
    output logic             wrap_pulse,
    output logic             at_max,
    output logic             at_min
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int KI = 0;
    localparam int KD = 1;
    localparam int KC = 2;
    localparam logic [HW-1:0]    HOLD_DONE = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH:0]   STEP_W    = (WIDTH + 1)'(STEP);

    if (STEP < 1 || STEP >= (1 << WIDTH) || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("key_updown_counter: parameter out of range");
    end

    logic [2:0]       key_raw;
    logic [2:0]       sync_q1;
    logic [2:0]       sync_q2;
    logic [2:0]       key_acc;
    logic [2:0]       key_evt;
    logic [HW-1:0]    hold_q [3];
    logic             clr_evt;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic             inc_only;
    logic             dec_only;
    logic [WIDTH-1:0] count_nxt;

    assign key_raw = {KEY_CLR, KEY_DEC, KEY_INC};

    // A press is accepted on the edge its hold counter steps onto HOLD_CYCLES.
    always_comb begin
        key_acc = '0;
        for (int k = 0; k < 3; k++) begin
            key_acc[k] = ~sync_q2[k] && (hold_q[k] == HOLD_LAST);
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_q [2];
    logic [1:0]    rep_fire;

    always_comb begin
        rep_fire = '0;
        for (int k = 0; k < 2; k++) begin
            rep_fire[k] = ~sync_q2[k] && (hold_q[k] == HOLD_DONE) && (rep_q[k] == REP_LAST);
        end
        key_evt = {key_acc[KC], key_acc[KD:KI] | rep_fire};
    end

    always_ff @(posedge FPGA_CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (RESET_BUT || sync_q2[k] || hold_q[k] != HOLD_DONE || rep_q[k] == REP_LAST) begin
                rep_q[k] <= '0;
            end else begin
                rep_q[k] <= rep_q[k] + RW'(1);
            end
        end
    end
`else
    assign key_evt = key_acc;
`endif

    always_comb begin
        sum_w     = {1'b0, count} + STEP_W;
        diff_w    = {1'b0, count} - STEP_W;
        inc_only  = inc_pulse & ~dec_pulse;
        dec_only  = dec_pulse & ~inc_pulse;
        count_nxt = count;
        if (clr_evt) begin
            count_nxt = '0;
        end else if (inc_only) begin
            count_nxt = (SAT_MODE != 0 && sum_w[WIDTH]) ? CNT_MAX : sum_w[WIDTH-1:0];
        end else if (dec_only) begin
            count_nxt = (SAT_MODE != 0 && diff_w[WIDTH]) ? '0 : diff_w[WIDTH-1:0];
        end
    end

    // Bit WIDTH of sum/diff flags carry/borrow out of range in either mode.
    assign wrap_pulse = (inc_only & sum_w[WIDTH]) | (dec_only & diff_w[WIDTH]);
    assign at_max     = (count == CNT_MAX);
    assign at_min     = (count == '0);

    always_ff @(posedge FPGA_CLK) begin
        if (RESET_BUT) begin
            sync_q1   <= '1;
            sync_q2   <= '1;
            for (int k = 0; k < 3; k++) begin
                hold_q[k] <= '0;
            end
            clr_evt   <= 1'b0;
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
            count     <= '0;
        end else begin
            sync_q1 <= key_raw;
            sync_q2 <= sync_q1;
            for (int k = 0; k < 3; k++) begin
                if (sync_q2[k]) begin
                    hold_q[k] <= '0;
                end else if (hold_q[k] != HOLD_DONE) begin
                    hold_q[k] <= hold_q[k] + HW'(1);
                end
            end
            // Clear wins over simultaneous inc/dec and suppresses their strobes.
            clr_evt   <= key_evt[KC];
            inc_pulse <= key_evt[KI] & ~key_evt[KC];
            dec_pulse <= key_evt[KD] & ~key_evt[KC];
            count     <= count_nxt;
        end
    end

endmodule

// File: tb/tb_key_updown_counter.sv
// Directed bench for key_updown_counter: wrap (dut0) and saturate (dut1) instances share inputs.
module tb_key_updown_counter;

    logic       FPGA_CLK = 1'b0;
    logic       RESET_BUT = 1'b1;
    logic       KEY_INC = 1'b1;
    logic       KEY_DEC = 1'b1;
    logic       KEY_CLR = 1'b1;
    logic [3:0] c0, c1;
    logic       ip0, dp0, wp0, mx0, mn0;
    logic       ip1, dp1, wp1, mx1, mn1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 FPGA_CLK = ~FPGA_CLK;

    key_updown_counter #(.WIDTH(4), .HOLD_CYCLES(4), .SAT_MODE(0), .STEP(1), .REPEAT_CYCLES(3)) dut0 (
        .FPGA_CLK(FPGA_CLK), .RESET_BUT(RESET_BUT), .KEY_INC(KEY_INC), .KEY_DEC(KEY_DEC),
        .KEY_CLR(KEY_CLR), .count(c0), .inc_pulse(ip0), .dec_pulse(dp0), .wrap_pulse(wp0),
        .at_max(mx0), .at_min(mn0));

    key_updown_counter #(.WIDTH(4), .HOLD_CYCLES(4), .SAT_MODE(1), .STEP(1), .REPEAT_CYCLES(3)) dut1 (
        .FPGA_CLK(FPGA_CLK), .RESET_BUT(RESET_BUT), .KEY_INC(KEY_INC), .KEY_DEC(KEY_DEC),
        .KEY_CLR(KEY_CLR), .count(c1), .inc_pulse(ip1), .dec_pulse(dp1), .wrap_pulse(wp1),
        .at_max(mx1), .at_min(mn1));

    typedef struct {
        logic [2:0] keys;   // {clr, dec, inc}, 1 = pressed
        int         len;
        int         cnt0;
        int         cnt1;
        int         inc;
        int         dec;
        int         w0;
        int         w1;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge FPGA_CLK);
        #1;
    endtask

    task automatic do_reset();
        KEY_INC = 1'b1;
        KEY_DEC = 1'b1;
        KEY_CLR = 1'b1;
        RESET_BUT = 1'b1;
        tick();
        tick();
        RESET_BUT = 1'b0;
    endtask

    // Hold the masked keys low for n cycles, release, let things settle; tally strobes.
    task automatic press(input logic [2:0] m, input int n,
                         output int ni, output int nd, output int nw0, output int nw1);
        ni = 0; nd = 0; nw0 = 0; nw1 = 0;
        KEY_INC = ~m[0];
        KEY_DEC = ~m[1];
        KEY_CLR = ~m[2];
        for (int i = 0; i < n + 6; i++) begin
            if (i == n) begin
                KEY_INC = 1'b1;
                KEY_DEC = 1'b1;
                KEY_CLR = 1'b1;
            end
            tick();
            ni  += int'(ip0);
            nd  += int'(dp0);
            nw0 += int'(wp0);
            nw1 += int'(wp1);
        end
    endtask

    initial begin
        int ni, nd, nw0, nw1;

        vecs[0] = '{3'b001, 3,  0,  0, 0, 0, 0, 0};
        vecs[1] = '{3'b001, 4,  1,  1, 1, 0, 0, 0};
        vecs[2] = '{3'b010, 10, 0,  0, 0, 1, 0, 0};
        vecs[3] = '{3'b010, 4,  15, 0, 0, 1, 1, 1};
        vecs[4] = '{3'b001, 4,  0,  1, 1, 0, 1, 0};
        vecs[5] = '{3'b100, 5,  0,  0, 0, 0, 0, 0};
        vecs[6] = '{3'b011, 4,  0,  0, 1, 1, 0, 0};
        vecs[7] = '{3'b010, 3,  0,  0, 0, 0, 0, 0};
        vecs[8] = '{3'b001, 6,  1,  1, 1, 0, 0, 0};

        do_reset();
        check("reset_count", int'(c0), 0);
        check("reset_pulses", int'({ip0, dp0, wp0, ip1, dp1, wp1}), 0);
        check("reset_at_min", int'(mn0), 1);
        check("reset_at_max", int'(mx0), 0);

        for (int v = 0; v < 9; v++) begin
            press(vecs[v].keys, vecs[v].len, ni, nd, nw0, nw1);
            check($sformatf("vec%0d_cnt0", v), int'(c0), vecs[v].cnt0);
            check($sformatf("vec%0d_cnt1", v), int'(c1), vecs[v].cnt1);
            check($sformatf("vec%0d_inc", v), ni, vecs[v].inc);
            check($sformatf("vec%0d_dec", v), nd, vecs[v].dec);
            check($sformatf("vec%0d_wrap0", v), nw0, vecs[v].w0);
            check($sformatf("vec%0d_wrap1", v), nw1, vecs[v].w1);
        end

        // Exact edge timing of a long hold from reset: one strobe at edge 6, count moves at 7.
        do_reset();
        KEY_INC = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("hold_e%0d_inc", k), int'(ip0), (k == 6) ? 1 : 0);
            check($sformatf("hold_e%0d_cnt", k), int'(c0), (k >= 7) ? 1 : 0);
        end
        KEY_INC = 1'b1;
        repeat (4) tick();

        // Top-of-range increment: wrap vs clip.
        do_reset();
        for (int i = 0; i < 15; i++) press(3'b001, 4, ni, nd, nw0, nw1);
        check("top_cnt0", int'(c0), 15);
        check("top_cnt1", int'(c1), 15);
        check("top_at_max0", int'(mx0), 1);
        KEY_INC = 1'b0;
        repeat (5) tick();
        tick();
        check("top_e6_pulse_wrap0", int'({ip0, wp0}), 3);
        check("top_e6_pulse_wrap1", int'({ip1, wp1}), 3);
        KEY_INC = 1'b1;
        tick();
        check("top_after_cnt0", int'(c0), 0);
        check("top_after_at_min0", int'(mn0), 1);
        check("top_after_cnt1", int'(c1), 15);
        check("top_after_at_max1", int'(mx1), 1);
        check("top_after_wrap0", int'(wp0), 0);
        repeat (4) tick();

        // Simultaneous inc/dec cancel at 5, then clear beats inc.
        do_reset();
        for (int i = 0; i < 5; i++) press(3'b001, 4, ni, nd, nw0, nw1);
        KEY_INC = 1'b0;
        KEY_DEC = 1'b0;
        repeat (5) tick();
        check("cancel_e5_quiet", int'({ip0, dp0}), 0);
        tick();
        check("cancel_e6_pulses", int'({ip0, dp0, wp0}), 6);
        tick();
        check("cancel_e7_pulses_gone", int'({ip0, dp0}), 0);
        check("cancel_cnt", int'(c0), 5);
        KEY_INC = 1'b1;
        KEY_DEC = 1'b1;
        repeat (4) tick();
        press(3'b101, 4, ni, nd, nw0, nw1);
        check("clr_inc_cnt", int'(c0), 0);
        check("clr_inc_no_inc", ni, 0);
        check("clr_inc_no_wrap", nw0, 0);

        // Reset mid-hold of a DEC press discards the partial hold.
        do_reset();
        KEY_DEC = 1'b0;
        repeat (5) tick();
        RESET_BUT = 1'b1;
        tick();
        RESET_BUT = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("rst_e%0d_dec", k), int'(dp0), (k == 6) ? 1 : 0);
            check($sformatf("rst_e%0d_wrap", k), int'(wp0), (k == 6) ? 1 : 0);
            check($sformatf("rst_e%0d_cnt0", k), int'(c0), (k >= 7) ? 15 : 0);
        end
        check("rst_cnt1", int'(c1), 0);
        KEY_DEC = 1'b1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
